// File: rtl/memc_sgl_arbiter_pkg.sv
// Shared memory-controller request/response types and the command-kind helper
// used by the single-access port arbiter.
package memc_sgl_arbiter_pkg;

  typedef enum logic [3:0] {
    MEMC_NONE       = 4'd0,
    MEMC_READ_BYTE  = 4'd1,
    MEMC_READ_HALF  = 4'd2,
    MEMC_READ_WORD  = 4'd3,
    MEMC_WRITE_BYTE = 4'd4,
    MEMC_WRITE_HALF = 4'd5,
    MEMC_WRITE_WORD = 4'd6
  } MemC_Cmd;

  typedef enum logic {
    KIND_LOAD  = 1'b0,
    KIND_STORE = 1'b1
  } MemcReqKind;

  typedef struct packed {
    MemC_Cmd     cmd;
    logic [31:0] readAddr;
    logic [31:0] writeAddr;
    logic [31:0] data;
  } MemController_Req;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } MemC_SglRes;

  typedef struct packed {
    logic [2:0] stall;
    MemC_SglRes sglLdRes;
    MemC_SglRes sglStRes;
    MemC_SglRes cacheLdRes;
  } MemController_Res;

  // Stall bit owned by the single-access port.
  localparam int STALL_SGL = 2;

  function automatic MemcReqKind memcReqKind(input MemC_Cmd cmd);
    case (cmd)
      MEMC_READ_BYTE, MEMC_READ_HALF, MEMC_READ_WORD: return KIND_LOAD;
      default:                                        return KIND_STORE;
    endcase
  endfunction

  function automatic logic isLoad(input MemC_Cmd cmd);
    return memcReqKind(cmd) == KIND_LOAD;
  endfunction

endpackage

// File: rtl/memc_sgl_arbiter_if.sv
// Request/response bundle between the single-access requesters, the arbiter
// and the memory controller's uncached port.
interface memc_sgl_arbiter_if #(parameter int NUM_REQ = 2);
  import memc_sgl_arbiter_pkg::*;

  MemController_Req IN_req  [NUM_REQ];
  MemController_Res OUT_res [NUM_REQ];
  MemController_Req OUT_memc;
  MemController_Res IN_memc;

  modport slave  (input IN_req, IN_memc, output OUT_res, OUT_memc);
  modport master (output IN_req, IN_memc, input OUT_res, OUT_memc);
endinterface

// File: rtl/memc_sgl_arbiter_owner_fifo.sv
// In-order FIFO of requester IDs that own outstanding single-access operations.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module memc_sgl_arbiter_owner_fifo #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] pushId,
  input  logic            pop,
  output logic [ID_W-1:0] head,
  output logic            full,
  output logic            empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ID_W-1:0] mem [DEPTH];
  logic [PW-1:0]   rdPtr, wrPtr;
  logic [CW-1:0]   count;
  logic            doPush, doPop;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign head   = mem[rdPtr];
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= ptrInc(wrPtr);
      if (doPop)  rdPtr <= ptrInc(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushId;
  end
endmodule

// File: rtl/memc_sgl_arbiter.sv
// Round-robin arbiter for the memory controller's single-access port; routes
// each load/store response back to the requester that issued it.
module memc_sgl_arbiter
  import memc_sgl_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUT = 2
) (
  input  logic               clk,
  input  logic               rst,
  memc_sgl_arbiter_if.slave  bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, ISSUE} State_t;

  State_t           state, nextState;
  MemController_Req memcReg, memcNext;
  logic [GW-1:0]    lastGrant, grantIdx, ldHead, stHead;
  logic [NUM_REQ-1:0] eligible;
  logic             slotFree, grantVld, found;
  logic             ldPush, stPush, ldPop, stPop;
  logic             ldFull, stFull, ldEmpty, stEmpty;
  int               rrIdx;

  assign ldPop    = bus.IN_memc.sglLdRes.valid && !ldEmpty;
  assign stPop    = bus.IN_memc.sglStRes.valid && !stEmpty;
  assign slotFree = (state == IDLE) || !bus.IN_memc.stall[STALL_SGL];

  // A full FIFO still has room when a same-kind response frees its head now.
  for (genvar i = 0; i < NUM_REQ; i++) begin : gElig
    assign eligible[i] = (bus.IN_req[i].cmd != MEMC_NONE) &&
                         (isLoad(bus.IN_req[i].cmd) ? (!ldFull || ldPop)
                                                    : (!stFull || stPop));
  end

  always_comb begin
    found    = 1'b0;
    grantIdx = lastGrant;
    rrIdx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rrIdx = int'(lastGrant) + k;
      if (rrIdx >= NUM_REQ) rrIdx = rrIdx - NUM_REQ;
      if (!found && eligible[GW'(rrIdx)]) begin
        found    = 1'b1;
        grantIdx = GW'(rrIdx);
      end
    end
    grantVld = found && slotFree;
  end

  assign ldPush = grantVld && isLoad(bus.IN_req[grantIdx].cmd);
  assign stPush = grantVld && !isLoad(bus.IN_req[grantIdx].cmd);

  always_comb begin
    nextState = state;
    memcNext  = memcReg;
    if (grantVld) begin
      nextState = ISSUE;
      memcNext  = bus.IN_req[grantIdx];
    end else if (state == ISSUE && !bus.IN_memc.stall[STALL_SGL]) begin
      nextState    = IDLE;
      memcNext     = 'x;
      memcNext.cmd = MEMC_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      memcReg   <= '0;
      lastGrant <= GW'(NUM_REQ - 1);
    end else begin
      state   <= nextState;
      memcReg <= memcNext;
      if (grantVld) lastGrant <= grantIdx;
    end
  end

  assign bus.OUT_memc = memcReg;

  for (genvar i = 0; i < NUM_REQ; i++) begin : gRes
    always_comb begin
      bus.OUT_res[i]                   = bus.IN_memc;
      bus.OUT_res[i].stall[STALL_SGL]  = !(grantVld && grantIdx == GW'(i));
      bus.OUT_res[i].sglLdRes.valid    = ldPop && (ldHead == GW'(i));
      bus.OUT_res[i].sglStRes.valid    = stPop && (stHead == GW'(i));
    end
  end

  memc_sgl_arbiter_owner_fifo #(.DEPTH(MAX_OUT), .ID_W(GW)) ldFifo (
    .clk(clk), .rst(rst), .push(ldPush), .pushId(grantIdx), .pop(ldPop),
    .head(ldHead), .full(ldFull), .empty(ldEmpty)
  );

  memc_sgl_arbiter_owner_fifo #(.DEPTH(MAX_OUT), .ID_W(GW)) stFifo (
    .clk(clk), .rst(rst), .push(stPush), .pushId(grantIdx), .pop(stPop),
    .head(stHead), .full(stFull), .empty(stEmpty)
  );

  // A response with no recorded owner is dropped; it must never happen.
  noOrphanLd: assert property (@(posedge clk) disable iff (rst)
                               !(bus.IN_memc.sglLdRes.valid && ldEmpty));
  noOrphanSt: assert property (@(posedge clk) disable iff (rst)
                               !(bus.IN_memc.sglStRes.valid && stEmpty));
endmodule

// File: tb/tb_memc_sgl_arbiter.sv
// Directed bench for memc_sgl_arbiter: grant order, stall hold, ownership
// limits, response routing and asynchronous reset.
module tb_memc_sgl_arbiter;
  import memc_sgl_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nTests = 0;
  int   nFails = 0;

  always #5 clk = ~clk;

  memc_sgl_arbiter_if #(.NUM_REQ(2)) bus ();

  memc_sgl_arbiter #(.NUM_REQ(2), .MAX_OUT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    for (int i = 0; i < 2; i++) bus.IN_req[i] = '0;
    bus.IN_memc = '0;
  endtask

  task automatic doReset();
    clearIn();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic setReq(input int i, input MemC_Cmd c, input logic [31:0] a);
    bus.IN_req[i].cmd       = c;
    bus.IN_req[i].readAddr  = a;
    bus.IN_req[i].writeAddr = a;
    bus.IN_req[i].data      = a ^ 32'h5A5A_5A5A;
  endtask

  task automatic test_reset();
    doReset();
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_NONE) begin
      nFails++; $display("FAIL reset_cmd: got %0d want %0d", bus.OUT_memc.cmd, MEMC_NONE);
    end
    nTests++;
    if (bus.OUT_memc.readAddr !== 32'h0) begin
      nFails++; $display("FAIL reset_addr: got %h want 0", bus.OUT_memc.readAddr);
    end
    nTests++;
    if (bus.OUT_res[0].stall[2] !== 1'b1 || bus.OUT_res[1].stall[2] !== 1'b1) begin
      nFails++; $display("FAIL reset_stall: got %b%b want 11",
                         bus.OUT_res[1].stall[2], bus.OUT_res[0].stall[2]);
    end
    bus.IN_memc.stall            = 3'b011;
    bus.IN_memc.cacheLdRes.valid = 1'b1;
    bus.IN_memc.cacheLdRes.data  = 32'hCAFE_0001;
    #1;
    nTests++;
    if (bus.OUT_res[0].stall !== 3'b111) begin
      nFails++; $display("FAIL bcast_stall: got %b want 111", bus.OUT_res[0].stall);
    end
    nTests++;
    if (bus.OUT_res[1].cacheLdRes !== {1'b1, 32'hCAFE_0001}) begin
      nFails++; $display("FAIL bcast_cache: got %h want 1cafe0001", bus.OUT_res[1].cacheLdRes);
    end
    clearIn();
  endtask

  task automatic test_single_load();
    doReset();
    setReq(1, MEMC_READ_WORD, 32'h8000_0010);
    #1;
    nTests++;
    if (bus.OUT_res[1].stall[2] !== 1'b0 || bus.OUT_res[0].stall[2] !== 1'b1) begin
      nFails++; $display("FAIL single_grant: got r1=%b r0=%b want r1=0 r0=1",
                         bus.OUT_res[1].stall[2], bus.OUT_res[0].stall[2]);
    end
    tick();
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_READ_WORD || bus.OUT_memc.readAddr !== 32'h8000_0010) begin
      nFails++; $display("FAIL single_issue: got cmd=%0d addr=%h want cmd=%0d addr=80000010",
                         bus.OUT_memc.cmd, bus.OUT_memc.readAddr, MEMC_READ_WORD);
    end
    bus.IN_req[1] = '0;
    tick();
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_NONE) begin
      nFails++; $display("FAIL single_idle: got %0d want %0d", bus.OUT_memc.cmd, MEMC_NONE);
    end
    bus.IN_memc.sglLdRes.valid = 1'b1;
    bus.IN_memc.sglLdRes.data  = 32'hDEAD_BEEF;
    #1;
    nTests++;
    if (bus.OUT_res[1].sglLdRes !== {1'b1, 32'hDEAD_BEEF}) begin
      nFails++; $display("FAIL single_resp1: got %h want 1deadbeef", bus.OUT_res[1].sglLdRes);
    end
    nTests++;
    if (bus.OUT_res[0].sglLdRes !== {1'b0, 32'hDEAD_BEEF}) begin
      nFails++; $display("FAIL single_resp0: got %h want 0deadbeef", bus.OUT_res[0].sglLdRes);
    end
    tick();
    clearIn();
  endtask

  task automatic test_round_robin();
    int g;
    int owner;
    logic [31:0] expAddr;
    doReset();
    for (int k = 0; k < 4; k++) begin
      setReq(0, MEMC_READ_WORD, 32'h1000 + 32'(k * 16));
      setReq(1, MEMC_READ_WORD, 32'h2000 + 32'(k * 16));
      bus.IN_memc.sglLdRes.valid = (k > 0);
      bus.IN_memc.sglLdRes.data  = 32'(k);
      #1;
      g = k % 2;
      nTests++;
      if (bus.OUT_res[g].stall[2] !== 1'b0 || bus.OUT_res[1-g].stall[2] !== 1'b1) begin
        nFails++; $display("FAIL rr_grant%0d: got r0=%b r1=%b want grant to %0d", k,
                           bus.OUT_res[0].stall[2], bus.OUT_res[1].stall[2], g);
      end
      if (k > 0) begin
        owner = (k - 1) % 2;
        nTests++;
        if (bus.OUT_res[owner].sglLdRes.valid !== 1'b1 ||
            bus.OUT_res[1-owner].sglLdRes.valid !== 1'b0) begin
          nFails++; $display("FAIL rr_resp%0d: got v0=%b v1=%b want owner %0d", k,
                             bus.OUT_res[0].sglLdRes.valid, bus.OUT_res[1].sglLdRes.valid, owner);
        end
      end
      tick();
      expAddr = (g == 1 ? 32'h2000 : 32'h1000) + 32'(k * 16);
      nTests++;
      if (bus.OUT_memc.cmd !== MEMC_READ_WORD || bus.OUT_memc.readAddr !== expAddr) begin
        nFails++; $display("FAIL rr_issue%0d: got cmd=%0d addr=%h want addr=%h", k,
                           bus.OUT_memc.cmd, bus.OUT_memc.readAddr, expAddr);
      end
    end
    clearIn();
    bus.IN_memc.sglLdRes.valid = 1'b1;
    bus.IN_memc.sglLdRes.data  = 32'h4;
    #1;
    nTests++;
    if (bus.OUT_res[1].sglLdRes.valid !== 1'b1 || bus.OUT_res[0].sglLdRes.valid !== 1'b0) begin
      nFails++; $display("FAIL rr_last_resp: got v0=%b v1=%b want v1 only",
                         bus.OUT_res[0].sglLdRes.valid, bus.OUT_res[1].sglLdRes.valid);
    end
    tick();
    clearIn();
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_NONE) begin
      nFails++; $display("FAIL rr_idle: got %0d want %0d", bus.OUT_memc.cmd, MEMC_NONE);
    end
  endtask

  task automatic test_stall_hold();
    doReset();
    setReq(0, MEMC_WRITE_BYTE, 32'h3000);
    #1;
    nTests++;
    if (bus.OUT_res[0].stall[2] !== 1'b0) begin
      nFails++; $display("FAIL stall_first_grant: got %b want 0", bus.OUT_res[0].stall[2]);
    end
    tick();
    bus.IN_req[0] = '0;
    setReq(1, MEMC_READ_WORD, 32'h4000);
    bus.IN_memc.stall = 3'b100;
    for (int c = 0; c < 3; c++) begin
      #1;
      nTests++;
      if (bus.OUT_res[0].stall[2] !== 1'b1 || bus.OUT_res[1].stall[2] !== 1'b1) begin
        nFails++; $display("FAIL stall_req%0d: got r0=%b r1=%b want 11", c,
                           bus.OUT_res[0].stall[2], bus.OUT_res[1].stall[2]);
      end
      tick();
      nTests++;
      if (bus.OUT_memc.cmd !== MEMC_WRITE_BYTE || bus.OUT_memc.writeAddr !== 32'h3000) begin
        nFails++; $display("FAIL stall_hold%0d: got cmd=%0d addr=%h want cmd=%0d addr=3000", c,
                           bus.OUT_memc.cmd, bus.OUT_memc.writeAddr, MEMC_WRITE_BYTE);
      end
    end
    bus.IN_memc.stall = 3'b000;
    #1;
    nTests++;
    if (bus.OUT_res[1].stall[2] !== 1'b0) begin
      nFails++; $display("FAIL stall_release: got %b want 0", bus.OUT_res[1].stall[2]);
    end
    tick();
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_READ_WORD || bus.OUT_memc.readAddr !== 32'h4000) begin
      nFails++; $display("FAIL stall_b2b: got cmd=%0d addr=%h want cmd=%0d addr=4000",
                         bus.OUT_memc.cmd, bus.OUT_memc.readAddr, MEMC_READ_WORD);
    end
    clearIn();
  endtask

  task automatic test_max_out();
    doReset();
    for (int k = 0; k < 2; k++) begin
      setReq(0, MEMC_READ_WORD, 32'h5000 + 32'(k * 4));
      #1;
      nTests++;
      if (bus.OUT_res[0].stall[2] !== 1'b0) begin
        nFails++; $display("FAIL max_accept%0d: got %b want 0", k, bus.OUT_res[0].stall[2]);
      end
      tick();
    end
    setReq(0, MEMC_READ_WORD, 32'h5008);
    for (int c = 0; c < 2; c++) begin
      #1;
      nTests++;
      if (bus.OUT_res[0].stall[2] !== 1'b1) begin
        nFails++; $display("FAIL max_full%0d: got %b want 1", c, bus.OUT_res[0].stall[2]);
      end
      tick();
    end
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_NONE) begin
      nFails++; $display("FAIL max_idle: got %0d want %0d", bus.OUT_memc.cmd, MEMC_NONE);
    end
    bus.IN_memc.sglLdRes.valid = 1'b1;
    bus.IN_memc.sglLdRes.data  = 32'h11;
    #1;
    nTests++;
    if (bus.OUT_res[0].stall[2] !== 1'b0 || bus.OUT_res[0].sglLdRes.valid !== 1'b1) begin
      nFails++; $display("FAIL max_pop_accept: got stall=%b valid=%b want stall=0 valid=1",
                         bus.OUT_res[0].stall[2], bus.OUT_res[0].sglLdRes.valid);
    end
    tick();
    bus.IN_memc = '0;
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_READ_WORD || bus.OUT_memc.readAddr !== 32'h5008) begin
      nFails++; $display("FAIL max_third_issue: got cmd=%0d addr=%h want addr=5008",
                         bus.OUT_memc.cmd, bus.OUT_memc.readAddr);
    end
    setReq(0, MEMC_READ_WORD, 32'h500C);
    #1;
    nTests++;
    if (bus.OUT_res[0].stall[2] !== 1'b1) begin
      nFails++; $display("FAIL max_still_full: got %b want 1", bus.OUT_res[0].stall[2]);
    end
    tick();
    clearIn();
  endtask

  task automatic test_simul_resp();
    doReset();
    setReq(0, MEMC_WRITE_WORD, 32'h6000);
    #1;
    tick();
    bus.IN_req[0] = '0;
    setReq(1, MEMC_READ_HALF, 32'h7000);
    #1;
    nTests++;
    if (bus.OUT_res[1].stall[2] !== 1'b0) begin
      nFails++; $display("FAIL simul_grant1: got %b want 0", bus.OUT_res[1].stall[2]);
    end
    tick();
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_READ_HALF) begin
      nFails++; $display("FAIL simul_issue1: got %0d want %0d", bus.OUT_memc.cmd, MEMC_READ_HALF);
    end
    clearIn();
    bus.IN_memc.sglStRes.valid = 1'b1;
    bus.IN_memc.sglStRes.data  = 32'h55;
    bus.IN_memc.sglLdRes.valid = 1'b1;
    bus.IN_memc.sglLdRes.data  = 32'h1234;
    #1;
    nTests++;
    if (bus.OUT_res[0].sglStRes.valid !== 1'b1 || bus.OUT_res[1].sglStRes.valid !== 1'b0) begin
      nFails++; $display("FAIL simul_st_route: got v0=%b v1=%b want v0 only",
                         bus.OUT_res[0].sglStRes.valid, bus.OUT_res[1].sglStRes.valid);
    end
    nTests++;
    if (bus.OUT_res[1].sglLdRes !== {1'b1, 32'h1234} || bus.OUT_res[0].sglLdRes.valid !== 1'b0) begin
      nFails++; $display("FAIL simul_ld_route: got r1=%h v0=%b want r1=100001234 v0=0",
                         bus.OUT_res[1].sglLdRes, bus.OUT_res[0].sglLdRes.valid);
    end
    tick();
    clearIn();
    nTests++;
    if (dut.ldEmpty !== 1'b1 || dut.stEmpty !== 1'b1) begin
      nFails++; $display("FAIL simul_empty: got ld=%b st=%b want 11", dut.ldEmpty, dut.stEmpty);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    setReq(0, MEMC_READ_WORD, 32'h8000);
    #1;
    tick();
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_READ_WORD) begin
      nFails++; $display("FAIL arst_pre: got %0d want %0d", bus.OUT_memc.cmd, MEMC_READ_WORD);
    end
    bus.IN_req[0]     = '0;
    bus.IN_memc.stall = 3'b100;
    #2 rst = 1'b1;
    #1;
    nTests++;
    if (bus.OUT_memc.cmd !== MEMC_NONE) begin
      nFails++; $display("FAIL arst_clear: got %0d want %0d", bus.OUT_memc.cmd, MEMC_NONE);
    end
    nTests++;
    if (dut.ldEmpty !== 1'b1) begin
      nFails++; $display("FAIL arst_fifo: got %b want 1", dut.ldEmpty);
    end
    #1 rst = 1'b0;
    clearIn();
    setReq(0, MEMC_READ_WORD, 32'h9000);
    setReq(1, MEMC_READ_WORD, 32'hA000);
    #1;
    nTests++;
    if (bus.OUT_res[0].stall[2] !== 1'b0 || bus.OUT_res[1].stall[2] !== 1'b1) begin
      nFails++; $display("FAIL arst_prio: got r0=%b r1=%b want r0=0 r1=1",
                         bus.OUT_res[0].stall[2], bus.OUT_res[1].stall[2]);
    end
    tick();
    nTests++;
    if (bus.OUT_memc.readAddr !== 32'h9000) begin
      nFails++; $display("FAIL arst_issue: got %h want 9000", bus.OUT_memc.readAddr);
    end
    clearIn();
    tick();
  endtask

  initial begin
    clearIn();
    test_reset();
    test_single_load();
    test_round_robin();
    test_stall_hold();
    test_max_out();
    test_simul_resp();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end
endmodule
